data_sync_ctrl: RTL and testbench

Destination-domain controller for a multi-bit bus crossing under a toggle req/ack handshake. It synchronizes the source's BUS_REQ toggle through an internal NUM_STAGES flop chain and captures UNSYNC_BUS once the toggle is seen. It then presents the word to a local consumer with a one-cycle ENABLE_PULSE and a held SYNC_VALID, and returns an ACK toggle once the consumer accepts. It sits beside the bit synchronizers as the sequencer that makes a bus-wide crossing safe.

---
 rtl/data_sync_ctrl.sv | 115 +++++++++++
 tb/tb_data_sync_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_sync_ctrl.sv
// Destination-side sequencer for a toggle req/ack bus crossing: synchronizes BUS_REQ,
// captures UNSYNC_BUS, and hands the word to a local consumer. Optional macro: DATA_SYNC_CTRL_OVERRUN_EN.
module data_sync_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_REQ,
  input  logic                 SYNC_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  output logic                 ENABLE_PULSE,
  output logic                 ACK,
  output logic                 OVERRUN,
  output logic                 dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_STAGES-1:0]  sync_q, sync_d;
  logic [BUS_WIDTH-1:0]   sync_bus_q, sync_bus_d;
  logic                   sync_valid_q, sync_valid_d;
  logic                   enable_pulse_q, enable_pulse_d;
  logic                   ack_q, ack_d;
  logic                   req_s;
  logic                   pending;

  assign req_s   = sync_q[NUM_STAGES-1];
  // pending is a level comparison, so a toggle arriving while busy is never lost.
  assign pending = req_s ^ ack_q;

  always_comb begin
    sync_d         = {sync_q[NUM_STAGES-2:0], BUS_REQ};
    state_d        = state_q;
    sync_bus_d     = sync_bus_q;
    sync_valid_d   = sync_valid_q;
    enable_pulse_d = 1'b0;
    ack_d          = ack_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          sync_bus_d     = UNSYNC_BUS;
          sync_valid_d   = 1'b1;
          enable_pulse_d = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        // Leaving HOLD never captures on the same edge; a still-pending toggle waits one cycle.
        if (SYNC_READY) begin
          sync_valid_d = 1'b0;
          ack_d        = ~ack_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      sync_bus_q     <= '0;
      sync_valid_q   <= 1'b0;
      enable_pulse_q <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      sync_bus_q     <= sync_bus_d;
      sync_valid_q   <= sync_valid_d;
      enable_pulse_q <= enable_pulse_d;
      ack_q          <= ack_d;
    end
  end

`ifdef DATA_SYNC_CTRL_OVERRUN_EN
  logic req_q, req_d;
  logic overrun_q, overrun_d;

  // A change of req_s while still holding means the source toggled again before ACK.
  always_comb begin
    req_d     = req_s;
    overrun_d = overrun_q | ((state_q == HOLD) && (req_s != req_q));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      overrun_q <= overrun_d;
    end
  end

  assign OVERRUN = overrun_q;
`else
  assign OVERRUN = 1'b0;
`endif

  assign SYNC_BUS     = sync_bus_q;
  assign SYNC_VALID   = sync_valid_q;
  assign ENABLE_PULSE = enable_pulse_q;
  assign ACK          = ack_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Directed, table-driven bench for data_sync_ctrl (NUM_STAGES=2, BUS_WIDTH=8).
module tb_data_sync_ctrl;

  localparam int W = 8;
`ifdef DATA_SYNC_CTRL_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] unsync_bus;
  logic         bus_req;
  logic         sync_ready;
  logic [W-1:0] sync_bus;
  logic         sync_valid;
  logic         enable_pulse;
  logic         ack;
  logic         overrun;
  logic         dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic         req;
    logic         rdy;
    logic [W-1:0] bus;
    logic [W-1:0] e_bus;
    logic         e_valid;
    logic         e_pulse;
    logic         e_ack;
    logic         e_ovr;
  } vec_t;

  vec_t vecs[$];

  data_sync_ctrl #(.BUS_WIDTH(W), .NUM_STAGES(2)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .UNSYNC_BUS   (unsync_bus),
    .BUS_REQ      (bus_req),
    .SYNC_READY   (sync_ready),
    .SYNC_BUS     (sync_bus),
    .SYNC_VALID   (sync_valid),
    .ENABLE_PULSE (enable_pulse),
    .ACK          (ack),
    .OVERRUN      (overrun),
    .dbg_state    (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic [W-1:0] e_bus,
                          input logic e_valid, input logic e_pulse, input logic e_ack, input logic e_ovr);
    chk({tag, ".sync_bus"},     idx, 32'(sync_bus),     32'(e_bus));
    chk({tag, ".sync_valid"},   idx, 32'(sync_valid),   32'(e_valid));
    chk({tag, ".enable_pulse"}, idx, 32'(enable_pulse), 32'(e_pulse));
    chk({tag, ".ack"},          idx, 32'(ack),          32'(e_ack));
    chk({tag, ".overrun"},      idx, 32'(overrun),      32'(e_ovr & OVR_EN));
  endtask

  task automatic add(input logic req, input logic rdy, input logic [W-1:0] bus,
                     input logic [W-1:0] e_bus, input logic e_valid, input logic e_pulse,
                     input logic e_ack, input logic e_ovr);
    vec_t v;
    v.req = req; v.rdy = rdy; v.bus = bus;
    v.e_bus = e_bus; v.e_valid = e_valid; v.e_pulse = e_pulse; v.e_ack = e_ack; v.e_ovr = e_ovr;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs driven before an edge, outputs expected just after it.
    for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    // single word, consumer always ready
    add(1, 1, 8'hA5, 8'h00, 0, 0, 0, 0);
    add(1, 1, 8'hA5, 8'h00, 0, 0, 0, 0);
    add(1, 1, 8'hA5, 8'hA5, 1, 1, 0, 0);
    add(1, 1, 8'hA5, 8'hA5, 0, 0, 1, 0);
    add(1, 1, 8'hA5, 8'hA5, 0, 0, 1, 0);
    // backpressure: ready low for 5 cycles after capture, bus disturbed after capture
    add(0, 0, 8'h96, 8'hA5, 0, 0, 1, 0);
    add(0, 0, 8'h96, 8'hA5, 0, 0, 1, 0);
    add(0, 0, 8'h96, 8'h96, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 8'hFF, 8'h96, 1, 0, 1, 0);
    add(0, 1, 8'hFF, 8'h96, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 8'h96, 0, 0, 0, 0);
    // back-to-back: second toggle issued the cycle ACK flips
    add(1, 1, 8'h11, 8'h96, 0, 0, 0, 0);
    add(1, 1, 8'h11, 8'h96, 0, 0, 0, 0);
    add(1, 1, 8'h11, 8'h11, 1, 1, 0, 0);
    add(1, 1, 8'h11, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h3C, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h3C, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h3C, 8'h3C, 1, 1, 1, 0);
    add(0, 1, 8'h3C, 8'h3C, 0, 0, 0, 0);
    add(0, 1, 8'h3C, 8'h3C, 0, 0, 0, 0);
    // toggle again while holding: overrun, then capture on the edge after leaving HOLD
    add(1, 0, 8'h77, 8'h3C, 0, 0, 0, 0);
    add(1, 0, 8'h77, 8'h3C, 0, 0, 0, 0);
    add(1, 0, 8'h77, 8'h77, 1, 1, 0, 0);
    add(0, 0, 8'h88, 8'h77, 1, 0, 0, 0);
    add(0, 0, 8'h88, 8'h77, 1, 0, 0, 0);
    add(0, 1, 8'h88, 8'h77, 0, 0, 1, 1);
    add(0, 1, 8'h88, 8'h88, 1, 1, 1, 1);
    add(0, 1, 8'h88, 8'h88, 0, 0, 0, 1);
    add(0, 1, 8'h88, 8'h88, 0, 0, 0, 1);
    // into HOLD with ready low, ahead of the mid-handshake reset
    add(1, 0, 8'h5A, 8'h88, 0, 0, 0, 1);
    add(1, 0, 8'h5A, 8'h88, 0, 0, 0, 1);
    add(1, 0, 8'h5A, 8'h5A, 1, 1, 0, 1);
    add(1, 0, 8'h5A, 8'h5A, 1, 0, 0, 1);

    // driver: reset
    rst_n      = 1'b1;
    bus_req    = 1'b0;
    sync_ready = 1'b0;
    unsync_bus = '0;
    #1 rst_n = 1'b0;
    #0.5;
    chk_outs("reset", 0, 8'h00, 0, 0, 0, 0);
    chk("reset.state", 0, 32'(dbg_state), 32'd0);
    #0.5 rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus_req    = vecs[i].req;
      sync_ready = vecs[i].rdy;
      unsync_bus = vecs[i].bus;
      @(posedge clk);
      #1;
      chk_outs("vec", i, vecs[i].e_bus, vecs[i].e_valid, vecs[i].e_pulse, vecs[i].e_ack, vecs[i].e_ovr);
    end

    // reset asserted mid-HOLD with BUS_REQ still high: outputs clear without an edge
    #2 rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", 0, 8'h00, 0, 0, 0, 0);
    chk("mid_rst.state", 0, 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    unsync_bus = 8'hE7;
    sync_ready = 1'b1;
    @(posedge clk); #1 chk_outs("post_rst", 1, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1 chk_outs("post_rst", 2, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1 chk_outs("post_rst", 3, 8'hE7, 1, 1, 0, 0);
    @(posedge clk); #1 chk_outs("post_rst", 4, 8'hE7, 0, 0, 1, 0);
    @(posedge clk); #1 chk_outs("post_rst", 5, 8'hE7, 0, 0, 1, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
